// File: rtl/register_bank_inc.sv
// Bank of NUM_REGS counters fed from the C bus. Each register can be loaded,
// incremented or decremented on its own, and raises a one-cycle wrap/clamp pulse.
module register_bank_inc #(
  parameter int                 WIDTH     = 16,
  parameter int                 NUM_REGS  = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 WRAP_MODE = 1,
  localparam int                AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    c_bus_in,
  input  logic [NUM_REGS-1:0] wr_sel,
  input  logic [NUM_REGS-1:0] inc_sel,
  input  logic [NUM_REGS-1:0] dec_sel,
  input  logic [AW-1:0]       rd_addr,
  output logic [WIDTH-1:0]    rd_data,
  output logic [NUM_REGS-1:0] zero_flags,
  output logic [NUM_REGS-1:0] wrap_evt
);

  localparam logic [WIDTH:0] ONE_EXT      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [AW:0]    NUM_REGS_EXT = (AW+1)'(NUM_REGS);
  localparam bit             SATURATE     = (WRAP_MODE == 0);

  logic [WIDTH-1:0]    r_regs    [NUM_REGS];
  logic [NUM_REGS-1:0] r_wrapEvt;

  logic [WIDTH:0]      w_incSum  [NUM_REGS];
  logic [WIDTH:0]      w_decDiff [NUM_REGS];
  logic [WIDTH-1:0]    w_next    [NUM_REGS];
  logic [NUM_REGS-1:0] w_evt;

  // The extra top bit of each sum/difference is the carry or borrow that flags the boundary.
  always_comb begin
    w_evt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_incSum[i]  = {1'b0, r_regs[i]} + ONE_EXT;
      w_decDiff[i] = {1'b0, r_regs[i]} - ONE_EXT;
      w_next[i]    = r_regs[i];
      if (wr_sel[i]) begin
        w_next[i] = c_bus_in;
      end else if (inc_sel[i] && !dec_sel[i]) begin
        w_evt[i] = w_incSum[i][WIDTH];
        if (!(SATURATE && w_incSum[i][WIDTH])) begin
          w_next[i] = w_incSum[i][WIDTH-1:0];
        end
      end else if (dec_sel[i] && !inc_sel[i]) begin
        w_evt[i] = w_decDiff[i][WIDTH];
        if (!(SATURATE && w_decDiff[i][WIDTH])) begin
          w_next[i] = w_decDiff[i][WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_wrapEvt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_next[i];
      end
      r_wrapEvt <= w_evt;
    end
  end

  // Out-of-range read addresses return zero rather than aliasing a real register.
  always_comb begin
    rd_data = '0;
    if ({1'b0, rd_addr} < NUM_REGS_EXT) begin
      rd_data = r_regs[rd_addr];
    end
  end

  always_comb begin
    zero_flags = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      zero_flags[i] = (r_regs[i] == '0);
    end
  end

  assign wrap_evt = r_wrapEvt;

endmodule

// File: doc/register_bank_inc.md
Name: register_bank_inc

Overview:
- Parametrised successor to the single-register blocks (plain, with-increment, data, instruction).
- Holds NUM_REGS general registers of WIDTH bits. Each register can be loaded from the C bus, incremented or decremented independently.
- Provides one combinational read port onto the B bus, per-register zero flags for the control unit (loop counters), and per-register wrap/saturation event pulses.
- Sits between the C bus (ALU result) and the B-bus mux in the processor datapath.

Parameters:
- WIDTH, 16, bit width of each register and of the bus ports.
- NUM_REGS, 8, number of registers (2..32).
- RESET_VAL, 0, value loaded into every register on reset.
- WRAP_MODE, 1, 1 = increment/decrement wrap modulo 2^WIDTH; 0 = saturate at all-ones / zero.

Ports:
- clk  input  1  system clock, rising edge active.
- rst_n  input  1  synchronous active-low reset.
- c_bus_in  input  WIDTH  load data from C bus.
- wr_sel  input  NUM_REGS  per-register write enable; multiple bits may be set.
- inc_sel  input  NUM_REGS  per-register increment request.
- dec_sel  input  NUM_REGS  per-register decrement request.
- rd_addr  input  clog2(NUM_REGS)  read register index.
- rd_data  output  WIDTH  contents of register rd_addr (combinational from state).
- zero_flags  output  NUM_REGS  bit i = 1 when register i == 0 (combinational from state).
- wrap_evt  output  NUM_REGS  registered one-cycle pulse per register on wrap or saturation clamp.

Behaviour:
- Reset: on a clk edge with rst_n=0, all registers become RESET_VAL and wrap_evt becomes 0. Reset overrides every request in that cycle. rd_data and zero_flags then follow the RESET_VAL contents (zero_flags all 1 when RESET_VAL = 0).
- Per register i, on each clk edge with rst_n=1, in priority order:
  - wr_sel[i]=1: reg <= c_bus_in. inc_sel and dec_sel are ignored; no wrap_evt.
  - inc_sel[i]=1 and dec_sel[i]=1: hold; no wrap_evt.
  - inc_sel[i]=1 only: reg <= reg+1.
  - dec_sel[i]=1 only: reg <= reg-1.
  - none set: hold.
- Width: the +1 and -1 are computed WIDTH+1 wide; the carry/borrow bit detects the boundary.
- Increment boundary, reg = all-ones:
  - WRAP_MODE=1: result is 0.
  - WRAP_MODE=0: result stays all-ones.
  - Either mode: wrap_evt[i]=1 for exactly the following cycle.
- Decrement boundary, reg = 0:
  - WRAP_MODE=1: result is all-ones.
  - WRAP_MODE=0: result stays 0.
  - Either mode: wrap_evt[i]=1 for the following cycle.
- wrap_evt[i] is 0 in every cycle that follows a non-boundary operation.
- Latency: writes and inc/dec are visible on rd_data and zero_flags one cycle after the capturing edge. No write-to-read bypass.
- Multiple wr_sel bits set: every selected register loads the same c_bus_in. This is legal.
- rd_addr >= NUM_REGS: rd_data = 0.
- All registers are updated in parallel. Operations on different registers in the same cycle are independent.
- No combinational path from c_bus_in, wr_sel, inc_sel or dec_sel to any output.

Test Plan:
1. Reset with rst_n=0 and wr_sel all ones, c_bus_in=16'hFFFF -> next cycle every register reads 0 via rd_addr sweep, zero_flags=8'hFF, wrap_evt=0.
2. Write reg3 with c_bus_in=16'd463 (wr_sel=8'h08), then inc_sel=8'h08 for one cycle -> rd_data(rd_addr=3)=463, then 464; other registers unchanged at 0.
3. Same cycle wr_sel[2]=1 (c_bus_in=16'd155), inc_sel[2]=1, dec_sel[5]=1 with reg5=10 -> reg2=155 (write wins), reg5=9.
4. WRAP_MODE=1, reg1=16'hFFFF, inc_sel[1]=1 -> reg1=0, zero_flags[1]=1, wrap_evt[1]=1 for exactly one cycle. Then dec_sel[1]=1 -> reg1=16'hFFFF with another one-cycle pulse.
5. WRAP_MODE=0 instance, reg0=0, dec_sel[0]=1 held for 3 cycles -> reg0 stays 0 and wrap_evt[0] high on each of the 3 following cycles. Then inc_sel[0]=1 and dec_sel[0]=1 together -> hold at 0, wrap_evt[0]=0.
6. Load reg6=5, dec_sel[6]=1 for 5 cycles, then assert rst_n=0 mid-sequence with inc_sel active -> zero_flags[6] rises after the 5th decrement, and reset forces all registers to 0 with wrap_evt cleared.
